// File: rtl/key_pkg.sv
// Shared constants for the key history block: default code width, mode encoding
// and display field positions.
package key_pkg;

    localparam int unsigned KEY_CODE_W = 9;

    localparam logic [0:0] LIVE   = 1'b0;
    localparam logic [0:0] BROWSE = 1'b1;

    localparam int unsigned CODE_LSB = 0;
    localparam int unsigned OFFS_LSB = 16;

endpackage

// File: rtl/key_history_ram.sv
// DEPTH x CODE_W history store: one synchronous write port, one asynchronous read port.
module key_history_ram #(
    parameter int unsigned CODE_W = 9,
    parameter int unsigned DEPTH  = 8,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [CODE_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [CODE_W-1:0] rdata
);

    logic [CODE_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/key_history.sv
// Circular key-code history with saturating counter and a LIVE/BROWSE display image
// for the 8-digit display driver.
module key_history
    import key_pkg::*;
#(
    parameter int unsigned CODE_W      = KEY_CODE_W,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned COUNT_W     = 16,
    parameter int unsigned TIMEOUT_CYC = 100_000_000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [CODE_W-1:0]        key_code,
    input  logic                     kc_valid,
    input  logic                     clear,
    input  logic                     scroll_up,
    input  logic                     scroll_down,
    output logic [COUNT_W-1:0]       key_count,
    output logic [$clog2(DEPTH):0]   fill,
    output logic                     browsing,
    output logic [31:0]              display,
    output logic [7:0]               digit_enable
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned FILL_W = PTR_W + 1;
    localparam int unsigned TMR_W  = $clog2(TIMEOUT_CYC);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_CYC - 1);

    logic [0:0]         state_q, state_d;
    logic [PTR_W-1:0]   offset_q, offset_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [31:0]        display_q, display_d;
    logic [7:0]         digit_enable_q, digit_enable_d;

    logic               wr_en;
    logic [PTR_W-1:0]   rd_idx;
    logic [CODE_W-1:0]  ram_rdata;
    logic [CODE_W-1:0]  entry;

    assign wr_en = kc_valid && !clear && !reset;

    always_comb begin
        state_d  = state_q;
        offset_d = offset_q;
        wr_ptr_d = wr_ptr_q;
        fill_d   = fill_q;
        count_d  = count_q;
        timer_d  = timer_q;
        if (clear) begin
            state_d  = LIVE;
            offset_d = '0;
            wr_ptr_d = '0;
            fill_d   = '0;
            count_d  = '0;
            timer_d  = '0;
        end else begin
            // Timer saturates so a write landing on the expiry cycle still times out next cycle.
            if (state_q == BROWSE && timer_q != TMR_MAX) begin
                timer_d = timer_q + TMR_W'(1);
            end
            if (kc_valid) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                if (fill_q != FILL_W'(DEPTH)) fill_d = fill_q + FILL_W'(1);
                if (!(&count_q)) count_d = count_q + COUNT_W'(1);
                if (state_q == BROWSE && offset_q != PTR_W'(DEPTH - 1)) begin
                    offset_d = offset_q + PTR_W'(1);
                end
            end else if (scroll_up) begin
                if (state_q == LIVE) begin
                    if (fill_q >= FILL_W'(2)) begin
                        state_d  = BROWSE;
                        offset_d = PTR_W'(1);
                        timer_d  = '0;
                    end
                end else begin
                    if ((FILL_W'(offset_q) + FILL_W'(1)) < fill_q) begin
                        offset_d = offset_q + PTR_W'(1);
                    end
                    timer_d = '0;
                end
            end else if (scroll_down) begin
                if (state_q == BROWSE) begin
                    if (offset_q == PTR_W'(1)) begin
                        state_d  = LIVE;
                        offset_d = '0;
                    end else begin
                        offset_d = offset_q - PTR_W'(1);
                    end
                    timer_d = '0;
                end
            end else if (state_q == BROWSE && timer_q == TMR_MAX) begin
                state_d  = LIVE;
                offset_d = '0;
                timer_d  = '0;
            end
        end
    end

    // Display is built from next state; a same-cycle write is forwarded past the RAM.
    assign rd_idx = wr_ptr_d - PTR_W'(1) - offset_d;
    assign entry  = (wr_en && rd_idx == wr_ptr_q) ? key_code : ram_rdata;

    always_comb begin
        display_d      = '0;
        digit_enable_d = '0;
        if (fill_d != '0) begin
            display_d[CODE_LSB +: CODE_W] = entry;
            if (state_d == BROWSE) display_d[OFFS_LSB +: PTR_W] = offset_d;
            digit_enable_d = {3'b000, state_d == BROWSE, 1'b0, entry[CODE_W-1], 2'b11};
        end
    end

    key_history_ram #(
        .CODE_W (CODE_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr_q),
        .wdata (key_code),
        .raddr (rd_idx),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= LIVE;
            offset_q       <= '0;
            wr_ptr_q       <= '0;
            fill_q         <= '0;
            count_q        <= '0;
            timer_q        <= '0;
            display_q      <= '0;
            digit_enable_q <= '0;
        end else begin
            state_q        <= state_d;
            offset_q       <= offset_d;
            wr_ptr_q       <= wr_ptr_d;
            fill_q         <= fill_d;
            count_q        <= count_d;
            timer_q        <= timer_d;
            display_q      <= display_d;
            digit_enable_q <= digit_enable_d;
        end
    end

    assign key_count    = count_q;
    assign fill         = fill_q;
    assign browsing     = (state_q == BROWSE);
    assign display      = display_q;
    assign digit_enable = digit_enable_q;

endmodule
